// File: rtl/tetris_pkg.sv
// Shared state encoding, default timing parameters and a counter-width helper
// for the Tetris sequencing controller.
package tetris_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SPAWN = 3'd1,
      ST_FALL  = 3'd2,
      ST_LOCK  = 3'd3,
      ST_CLEAR = 3'd4,
      ST_OVER  = 3'd5
   } state_e;

   localparam int unsigned GRAVITY_DIV_DEF = 25_000_000;
   localparam int unsigned REPEAT_DIV_DEF  = 10_000_000;
   localparam int unsigned LOCK_DELAY_DEF  = 2000;

   // Bits needed to hold any value in 0..n.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/btn_repeat.sv
// Rising-edge detect plus hold-to-repeat for one button; req_o is a
// same-cycle request that the controller registers into a move strobe.
module btn_repeat
   import tetris_pkg::*;
#(
   parameter int unsigned REPEAT_DIV = REPEAT_DIV_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic en_i,
   input  logic btn_i,
   output logic req_o
);

   localparam int unsigned RW = cnt_w(REPEAT_DIV);
   localparam logic [RW-1:0] RPT_MAX = RW'(REPEAT_DIV - 1);

   logic          prev_q;
   logic          armed_q, armed_d;
   logic [RW-1:0] cnt_q, cnt_d;
   logic          rise, rep;

   assign rise  = btn_i & ~prev_q;
   // Repeats only follow an edge seen while enabled, never a button already held on entry.
   assign rep   = btn_i & prev_q & armed_q & (cnt_q == RPT_MAX);
   assign req_o = en_i & (rise | rep);

   always_comb begin
      cnt_d   = '0;
      armed_d = 1'b0;
      if (en_i && btn_i) begin
         if (rise || rep) begin
            armed_d = 1'b1;
         end else if (armed_q) begin
            cnt_d   = cnt_q + RW'(1);
            armed_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q  <= 1'b0;
         armed_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         prev_q  <= btn_i;
         armed_q <= armed_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/tetris_seq_ctrl.sv
// Game sequencing FSM: spawn/fall/lock/clear flow, move arbitration,
// gravity timing and lock delay. All outputs are registered.
module tetris_seq_ctrl
   import tetris_pkg::*;
#(
   parameter int unsigned GRAVITY_DIV = GRAVITY_DIV_DEF,
   parameter int unsigned REPEAT_DIV  = REPEAT_DIV_DEF,
   parameter int unsigned LOCK_DELAY  = LOCK_DELAY_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       left_bound,
   input  logic       right_bound,
   input  logic       down_bound,
   input  logic       can_rotate,
   input  logic       clear_done,
   input  logic       spawn_blocked,
   output logic       mv_left,
   output logic       mv_right,
   output logic       mv_rotate,
   output logic       mv_down,
   output logic       lock_req,
   output logic       spawn_req,
   output logic       board_clear,
   output logic [2:0] state,
   output logic       game_over
);

   localparam int unsigned GW = cnt_w(GRAVITY_DIV);
   localparam int unsigned LW = cnt_w(LOCK_DELAY);
   localparam logic [GW-1:0] GRAV_MAX = GW'(GRAVITY_DIV - 1);
   localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_DELAY - 1);

   state_e        state_q, state_d;
   logic          spawn_wait_q, spawn_wait_d;
   logic [GW-1:0] grav_cnt_q, grav_cnt_d;
   logic          grav_pend_q, grav_pend_d;
   logic [LW-1:0] lock_cnt_q, lock_cnt_d;
   logic          mv_left_q, mv_right_q, mv_rotate_q, mv_down_q;
   logic          mv_left_d, mv_right_d, mv_rotate_d, mv_down_d;
   logic          lock_req_q, spawn_req_q, board_clear_q, game_over_q;
   logic          lock_req_d, spawn_req_d, board_clear_d, game_over_d;
   logic          req_left, req_right, req_up, req_down;
   logic          in_fall, lock_hit, grav_wrap;

   assign in_fall   = (state_q == ST_FALL);
   assign lock_hit  = in_fall & down_bound & (lock_cnt_q == LOCK_MAX);
   assign grav_wrap = (grav_cnt_q == GRAV_MAX);

   btn_repeat #(.REPEAT_DIV(REPEAT_DIV)) u_btn_left (
      .clk(clk), .reset(reset), .en_i(in_fall), .btn_i(btn_left), .req_o(req_left));
   btn_repeat #(.REPEAT_DIV(REPEAT_DIV)) u_btn_right (
      .clk(clk), .reset(reset), .en_i(in_fall), .btn_i(btn_right), .req_o(req_right));
   btn_repeat #(.REPEAT_DIV(REPEAT_DIV)) u_btn_up (
      .clk(clk), .reset(reset), .en_i(in_fall), .btn_i(btn_up), .req_o(req_up));
   btn_repeat #(.REPEAT_DIV(REPEAT_DIV)) u_btn_down (
      .clk(clk), .reset(reset), .en_i(in_fall), .btn_i(btn_down), .req_o(req_down));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         spawn_wait_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         spawn_wait_q <= spawn_wait_d;
      end
   end

   // SPAWN spends one cycle issuing spawn_req and one cycle sampling spawn_blocked.
   always_comb begin
      state_d      = state_q;
      spawn_wait_d = 1'b0;
      unique case (state_q)
         ST_IDLE:  if (start) state_d = ST_SPAWN;
         ST_SPAWN: begin
            if (spawn_wait_q) state_d = spawn_blocked ? ST_OVER : ST_FALL;
            else              spawn_wait_d = 1'b1;
         end
         ST_FALL:  if (lock_hit) state_d = ST_LOCK;
         ST_LOCK:  state_d = ST_CLEAR;
         ST_CLEAR: if (clear_done) state_d = ST_SPAWN;
         ST_OVER:  if (start) state_d = ST_SPAWN;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      board_clear_d = start & ((state_q == ST_IDLE) | (state_q == ST_OVER));
      spawn_req_d   = (state_q == ST_SPAWN) & ~spawn_wait_q;
      lock_req_d    = lock_hit;
      game_over_d   = (state_d == ST_OVER);
      mv_rotate_d   = 1'b0;
      mv_left_d     = 1'b0;
      mv_right_d    = 1'b0;
      mv_down_d     = 1'b0;
      if (in_fall && !lock_hit) begin
         if (req_up && can_rotate)                    mv_rotate_d = 1'b1;
         else if (req_left && !left_bound)            mv_left_d   = 1'b1;
         else if (req_right && !right_bound)          mv_right_d  = 1'b1;
         else if ((req_down || grav_pend_q) && !down_bound) mv_down_d = 1'b1;
      end
      // Counters and pending gravity hold zero outside FALL, so each entry starts clean.
      grav_cnt_d  = '0;
      grav_pend_d = 1'b0;
      lock_cnt_d  = '0;
      if (in_fall && state_d == ST_FALL) begin
         grav_cnt_d  = grav_wrap ? '0 : grav_cnt_q + GW'(1);
         grav_pend_d = grav_wrap | (grav_pend_q & ~mv_down_d);
         lock_cnt_d  = down_bound ? lock_cnt_q + LW'(1) : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         grav_cnt_q    <= '0;
         grav_pend_q   <= 1'b0;
         lock_cnt_q    <= '0;
         mv_left_q     <= 1'b0;
         mv_right_q    <= 1'b0;
         mv_rotate_q   <= 1'b0;
         mv_down_q     <= 1'b0;
         lock_req_q    <= 1'b0;
         spawn_req_q   <= 1'b0;
         board_clear_q <= 1'b0;
         game_over_q   <= 1'b0;
      end else begin
         grav_cnt_q    <= grav_cnt_d;
         grav_pend_q   <= grav_pend_d;
         lock_cnt_q    <= lock_cnt_d;
         mv_left_q     <= mv_left_d;
         mv_right_q    <= mv_right_d;
         mv_rotate_q   <= mv_rotate_d;
         mv_down_q     <= mv_down_d;
         lock_req_q    <= lock_req_d;
         spawn_req_q   <= spawn_req_d;
         board_clear_q <= board_clear_d;
         game_over_q   <= game_over_d;
      end
   end

   assign mv_left     = mv_left_q;
   assign mv_right    = mv_right_q;
   assign mv_rotate   = mv_rotate_q;
   assign mv_down     = mv_down_q;
   assign lock_req    = lock_req_q;
   assign spawn_req   = spawn_req_q;
   assign board_clear = board_clear_q;
   assign game_over   = game_over_q;
   assign state       = state_q;

endmodule

// File: tb/tb_tetris_seq_ctrl.sv
// Directed bench for tetris_seq_ctrl with GRAVITY_DIV=8, REPEAT_DIV=4, LOCK_DELAY=3.
module tb_tetris_seq_ctrl;

   logic clk = 1'b0;
   logic reset, start, btn_left, btn_right, btn_up, btn_down;
   logic left_bound, right_bound, down_bound, can_rotate, clear_done, spawn_blocked;
   logic mv_left, mv_right, mv_rotate, mv_down, lock_req, spawn_req, board_clear, game_over;
   logic [2:0] state;

   logic [10:0] obs, expv;
   int n_chk = 0;
   int n_pass = 0;

   localparam logic [7:0] O_NONE  = 8'b0000_0000;
   localparam logic [7:0] O_BCLR  = 8'b1000_0000;
   localparam logic [7:0] O_SPAWN = 8'b0100_0000;
   localparam logic [7:0] O_LOCK  = 8'b0010_0000;
   localparam logic [7:0] O_OVER  = 8'b0001_0000;
   localparam logic [7:0] O_ROT   = 8'b0000_1000;
   localparam logic [7:0] O_LEFT  = 8'b0000_0100;
   localparam logic [7:0] O_RIGHT = 8'b0000_0010;
   localparam logic [7:0] O_DOWN  = 8'b0000_0001;

   always #5 clk = ~clk;

   assign obs = {state, board_clear, spawn_req, lock_req, game_over,
                 mv_rotate, mv_left, mv_right, mv_down};

   tetris_seq_ctrl #(.GRAVITY_DIV(8), .REPEAT_DIV(4), .LOCK_DELAY(3)) dut (
      .clk(clk), .reset(reset), .start(start),
      .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
      .left_bound(left_bound), .right_bound(right_bound), .down_bound(down_bound),
      .can_rotate(can_rotate), .clear_done(clear_done), .spawn_blocked(spawn_blocked),
      .mv_left(mv_left), .mv_right(mv_right), .mv_rotate(mv_rotate), .mv_down(mv_down),
      .lock_req(lock_req), .spawn_req(spawn_req), .board_clear(board_clear),
      .state(state), .game_over(game_over));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      start = 0; btn_left = 0; btn_right = 0; btn_up = 0; btn_down = 0;
      left_bound = 0; right_bound = 0; down_bound = 0; can_rotate = 0;
      clear_done = 0; spawn_blocked = 0;
   endtask

   // Reset, start a game and stop on the first cycle the DUT reports FALL.
   task automatic enter_fall();
      clear_inputs();
      reset = 1; step();
      reset = 0; start = 1; step();
      start = 0; step();
      step();
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1; start = 1; clear_done = 1;
      step();
      expv = {3'd0, O_NONE}; n_chk++;
      if (obs !== expv) $display("FAIL reset_dominates: got %b expected %b", obs, expv); else n_pass++;
      reset = 0; start = 0; clear_done = 0;
      step();
      expv = {3'd0, O_NONE}; n_chk++;
      if (obs !== expv) $display("FAIL idle_holds: got %b expected %b", obs, expv); else n_pass++;
   endtask

   task automatic test_start();
      start = 1; step();
      expv = {3'd1, O_BCLR}; n_chk++;
      if (obs !== expv) $display("FAIL start_board_clear: got %b expected %b", obs, expv); else n_pass++;
      start = 0; step();
      expv = {3'd1, O_SPAWN}; n_chk++;
      if (obs !== expv) $display("FAIL start_spawn_req: got %b expected %b", obs, expv); else n_pass++;
      step();
      expv = {3'd2, O_NONE}; n_chk++;
      if (obs !== expv) $display("FAIL start_enter_fall: got %b expected %b", obs, expv); else n_pass++;
   endtask

   task automatic test_rotate_priority();
      enter_fall();
      btn_up = 1; btn_left = 1; can_rotate = 1; step();
      expv = {3'd2, O_ROT}; n_chk++;
      if (obs !== expv) $display("FAIL rotate_over_left: got %b expected %b", obs, expv); else n_pass++;
      btn_up = 0; btn_left = 0; step();
      expv = {3'd2, O_NONE}; n_chk++;
      if (obs !== expv) $display("FAIL left_dropped: got %b expected %b", obs, expv); else n_pass++;
      btn_up = 1; can_rotate = 0; step();
      expv = {3'd2, O_NONE}; n_chk++;
      if (obs !== expv) $display("FAIL rotate_blocked: got %b expected %b", obs, expv); else n_pass++;
      btn_up = 0; btn_left = 1; left_bound = 1; step();
      expv = {3'd2, O_NONE}; n_chk++;
      if (obs !== expv) $display("FAIL left_blocked: got %b expected %b", obs, expv); else n_pass++;
      btn_left = 0; left_bound = 0; start = 1; step();
      expv = {3'd2, O_NONE}; n_chk++;
      if (obs !== expv) $display("FAIL start_ignored_fall: got %b expected %b", obs, expv); else n_pass++;
      start = 0;
   endtask

   task automatic test_repeat();
      enter_fall();
      btn_right = 1;
      for (int i = 0; i < 10; i++) begin
         step();
         // Gravity wraps on edge 7; edge 8 belongs to the repeat, so the drop lands on edge 9.
         if (i % 4 == 0)  expv = {3'd2, O_RIGHT};
         else if (i == 9) expv = {3'd2, O_DOWN};
         else             expv = {3'd2, O_NONE};
         n_chk++;
         if (obs !== expv) $display("FAIL repeat_edge%0d: got %b expected %b", i, obs, expv); else n_pass++;
      end
      btn_right = 0; step();
      expv = {3'd2, O_NONE}; n_chk++;
      if (obs !== expv) $display("FAIL repeat_release: got %b expected %b", obs, expv); else n_pass++;
   endtask

   task automatic test_gravity();
      enter_fall();
      for (int i = 0; i < 7; i++) begin
         step();
         expv = {3'd2, O_NONE}; n_chk++;
         if (obs !== expv) $display("FAIL gravity_quiet%0d: got %b expected %b", i, obs, expv); else n_pass++;
      end
      btn_left = 1; step();
      expv = {3'd2, O_LEFT}; n_chk++;
      if (obs !== expv) $display("FAIL gravity_left_wins: got %b expected %b", obs, expv); else n_pass++;
      btn_up = 1; can_rotate = 1; step();
      expv = {3'd2, O_ROT}; n_chk++;
      if (obs !== expv) $display("FAIL gravity_rot_wins: got %b expected %b", obs, expv); else n_pass++;
      btn_up = 0; btn_left = 0; step();
      expv = {3'd2, O_DOWN}; n_chk++;
      if (obs !== expv) $display("FAIL gravity_down_free: got %b expected %b", obs, expv); else n_pass++;
      step();
      expv = {3'd2, O_NONE}; n_chk++;
      if (obs !== expv) $display("FAIL gravity_pend_clear: got %b expected %b", obs, expv); else n_pass++;
   endtask

   task automatic test_lock_flow();
      enter_fall();
      down_bound = 1; step(); step();
      down_bound = 0; step();
      expv = {3'd2, O_NONE}; n_chk++;
      if (obs !== expv) $display("FAIL lock_count_reset: got %b expected %b", obs, expv); else n_pass++;
      down_bound = 1; step(); step();
      expv = {3'd2, O_NONE}; n_chk++;
      if (obs !== expv) $display("FAIL lock_not_yet: got %b expected %b", obs, expv); else n_pass++;
      step();
      expv = {3'd3, O_LOCK}; n_chk++;
      if (obs !== expv) $display("FAIL lock_req: got %b expected %b", obs, expv); else n_pass++;
      down_bound = 0; start = 1; step();
      expv = {3'd4, O_NONE}; n_chk++;
      if (obs !== expv) $display("FAIL lock_to_clear: got %b expected %b", obs, expv); else n_pass++;
      step();
      expv = {3'd4, O_NONE}; n_chk++;
      if (obs !== expv) $display("FAIL clear_waits: got %b expected %b", obs, expv); else n_pass++;
      start = 0; clear_done = 1; step();
      expv = {3'd1, O_NONE}; n_chk++;
      if (obs !== expv) $display("FAIL clear_to_spawn: got %b expected %b", obs, expv); else n_pass++;
      clear_done = 0; spawn_blocked = 1; step();
      expv = {3'd1, O_SPAWN}; n_chk++;
      if (obs !== expv) $display("FAIL respawn_req: got %b expected %b", obs, expv); else n_pass++;
      step();
      expv = {3'd5, O_OVER}; n_chk++;
      if (obs !== expv) $display("FAIL game_over: got %b expected %b", obs, expv); else n_pass++;
      spawn_blocked = 0; clear_done = 1; step();
      expv = {3'd5, O_OVER}; n_chk++;
      if (obs !== expv) $display("FAIL over_holds: got %b expected %b", obs, expv); else n_pass++;
      clear_done = 0; start = 1; step();
      expv = {3'd1, O_BCLR}; n_chk++;
      if (obs !== expv) $display("FAIL over_restart: got %b expected %b", obs, expv); else n_pass++;
      start = 0;
   endtask

   task automatic test_reset_midflight();
      enter_fall();
      down_bound = 1; step(); step();
      reset = 1; step();
      expv = {3'd0, O_NONE}; n_chk++;
      if (obs !== expv) $display("FAIL reset_mid_lock: got %b expected %b", obs, expv); else n_pass++;
      reset = 0; step();
      expv = {3'd0, O_NONE}; n_chk++;
      if (obs !== expv) $display("FAIL idle_after_reset: got %b expected %b", obs, expv); else n_pass++;
      enter_fall();
      down_bound = 1; step(); step(); step();
      down_bound = 0; step();
      expv = {3'd4, O_NONE}; n_chk++;
      if (obs !== expv) $display("FAIL reach_clear: got %b expected %b", obs, expv); else n_pass++;
      reset = 1; clear_done = 1; start = 1; step();
      expv = {3'd0, O_NONE}; n_chk++;
      if (obs !== expv) $display("FAIL reset_in_clear: got %b expected %b", obs, expv); else n_pass++;
      reset = 0; clear_done = 0; start = 0; step();
      expv = {3'd0, O_NONE}; n_chk++;
      if (obs !== expv) $display("FAIL idle_after_clear_reset: got %b expected %b", obs, expv); else n_pass++;
   endtask

   initial begin
      clear_inputs();
      reset = 1;
      test_reset();
      test_start();
      test_rotate_priority();
      test_repeat();
      test_gravity();
      test_lock_flow();
      test_reset_midflight();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/tetris_seq_ctrl.md
TETRIS_SEQ_CTRL -- requirements
Module: tetris_seq_ctrl

Interface
REQ-001 Parameter GRAVITY_DIV, default 25_000_000, cycles per gravity tick (2 Hz at 50 MHz).
REQ-002 Parameter REPEAT_DIV, default 10_000_000, auto-repeat interval for a held button, in cycles.
REQ-003 Parameter LOCK_DELAY, default 2000, consecutive down_bound cycles before lock.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  level; begins or restarts a game.
REQ-007 btn_left, btn_right, btn_up, btn_down  input  1 each  synchronized button levels.
REQ-008 left_bound, right_bound, down_bound  input  1 each  piece blocked in that direction.
REQ-009 can_rotate  input  1  rotated piece fits.
REQ-010 clear_done  input  1  one-cycle pulse: datapath finished merge and row clear.
REQ-011 spawn_blocked  input  1  newly spawned piece overlaps background.
REQ-012 mv_left, mv_right, mv_rotate, mv_down  output  1 each  one-cycle move strobes to datapath.
REQ-013 lock_req, spawn_req, board_clear  output  1 each  one-cycle command strobes.
REQ-014 state  output  3  current FSM state encoding.
REQ-015 game_over  output  1  high while in OVER.

Function
REQ-016 The FSM SHALL have states IDLE=0, SPAWN=1, FALL=2, LOCK=3, CLEAR=4, OVER=5.
REQ-017 IDLE: when start=1, assert board_clear for one cycle, then enter SPAWN.
REQ-018 SPAWN: assert spawn_req for exactly one cycle; on the next cycle enter OVER if spawn_blocked=1, else FALL.
REQ-019 FALL: a button rising edge SHALL raise a request that same cycle; while held, it SHALL re-request every REPEAT_DIV cycles after the edge.
REQ-020 The gravity counter SHALL run only in FALL, wrap at GRAVITY_DIV-1, and set a sticky gravity-pending flag on wrap.
REQ-021 At most one mv_* strobe SHALL be high per cycle, with priority rotate > left > right > down (button or gravity-pending).
REQ-022 A request SHALL be granted only if unblocked: rotate needs can_rotate=1; left needs left_bound=0; right needs right_bound=0; down needs down_bound=0.
REQ-023 A blocked or lower-priority button request SHALL be dropped.
REQ-024 Gravity-pending SHALL clear only when mv_down is issued, or on leaving FALL.
REQ-025 The lock counter SHALL increment each FALL cycle with down_bound=1 and reset to 0 on any cycle with down_bound=0.
REQ-026 When the lock counter reaches LOCK_DELAY-1, the block SHALL assert lock_req for one cycle and enter LOCK; no mv_* strobe fires in that cycle.
REQ-027 LOCK SHALL move to CLEAR unconditionally on the next cycle.
REQ-028 CLEAR SHALL wait for clear_done, then enter SPAWN; clear_done outside CLEAR is ignored.
REQ-029 OVER: game_over=1; start=1 SHALL assert board_clear and enter SPAWN.
REQ-030 start SHALL be ignored in SPAWN, FALL, LOCK and CLEAR.
REQ-031 All counters SHALL be wide enough for their parameter, with no overflow; the gravity, repeat and lock counters clear on every FALL entry.
REQ-032 All outputs SHALL be registered, one-cycle latency from the qualifying input.

Reset
REQ-033 reset=1 SHALL force state=IDLE, clear all counters and pending flags, and drive every output to 0 on the next edge.
REQ-034 reset SHALL dominate all other inputs in the same cycle, including mid-CLEAR and mid-lock-count.

Structure
REQ-035 State encodings and default parameter values SHALL live in a shared package, tetris_pkg.
REQ-036 The per-button edge-detect and auto-repeat logic SHALL be one sub-module, btn_repeat, instantiated four times.
REQ-037 The FSM, arbiter, gravity counter and lock counter SHALL reside in tetris_seq_ctrl.

Verification (GRAVITY_DIV=8, REPEAT_DIV=4, LOCK_DELAY=3)
REQ-038 Reset, then start=1 -> board_clear at cycle 1, spawn_req at cycle 2, state=FALL at cycle 3.
REQ-039 In FALL, btn_up and btn_left rise together with can_rotate=1 -> only mv_rotate that cycle; left dropped.
REQ-040 btn_right held 10 cycles with right_bound=0 -> mv_right at edge+1, +5, +9 (REPEAT_DIV spacing).
REQ-041 down_bound held high -> no mv_down, lock_req after 3 cycles, then LOCK->CLEAR; clear_done -> spawn_req; spawn_blocked=1 -> state=OVER, game_over=1.
REQ-042 Gravity wrap while btn_left is granted -> mv_down issued on the next free cycle.
REQ-043 reset asserted in CLEAR -> state=IDLE, all outputs 0 next cycle.
